// File: rtl/gate_sequencer.sv
// Gate sequencer: buffers a password attempt, replays it to an external checker,
// reports the verdict and enforces a timed lockout after repeated failures.
//
// state   | meaning
// LOAD    | accept attempt bytes into the buffer
// STREAM  | replay buffered bytes to the checker, one per cycle
// CHECK   | sample the checker match flag
// REPORT  | one-cycle verdict strobe, update failure count
// LOCKOUT | refuse input for LOCK_CYCLES cycles
module gate_sequencer #(
    parameter int MAX_LEN     = 32,
    parameter int MAX_FAILS   = 3,
    parameter int LOCK_CYCLES = 1024
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [7:0]                     IN_BYTE,
    input  logic                           IN_VALID,
    input  logic                           IN_LAST,
    output logic                           IN_READY,
    output logic [7:0]                     CHK_BYTE,
    output logic                           CHK_RESET_N,
    input  logic                           CHK_GOOD,
    output logic                           RES_VALID,
    output logic                           RES_PASS,
    output logic                           LOCKED,
    output logic [$clog2(MAX_FAILS+1)-1:0] FAIL_COUNT
);
    localparam int PW  = $clog2(MAX_LEN + 1);
    localparam int AW  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int FCW = $clog2(MAX_FAILS + 1);
    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        LOAD,
        STREAM,
        CHECK,
        REPORT,
        LOCKOUT
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [7:0]     buffer [MAX_LEN];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           overflow;
    logic           verdict;
    logic [FCW-1:0] fail_count;
    logic [FCW-1:0] fail_inc;
    logic [LCW-1:0] lock_cnt;
    logic           xfer;
    logic           buf_we;
    logic           stream_done;
    logic           lock_done;

    // wr_ptr doubles as the attempt length once LAST has been taken
    assign IN_READY    = (state == LOAD) && !RESET;
    assign xfer        = IN_VALID && IN_READY;
    assign buf_we      = xfer && (wr_ptr < PW'(MAX_LEN));
    assign stream_done = (rd_ptr == wr_ptr - PW'(1));
    assign lock_done   = (lock_cnt == '0);
    assign fail_inc    = (fail_count == FCW'(MAX_FAILS)) ? fail_count : fail_count + FCW'(1);
    assign FAIL_COUNT  = fail_count;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        CHK_BYTE    = '0;
        CHK_RESET_N = 1'b0;
        RES_VALID   = 1'b0;
        RES_PASS    = 1'b0;
        LOCKED      = 1'b0;
        case (state)
            LOAD: begin
                if (xfer && IN_LAST) begin
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                CHK_RESET_N = 1'b1;
                CHK_BYTE    = buffer[rd_ptr[AW-1:0]];
                if (stream_done) begin
                    state_nx = CHECK;
                end
            end
            CHECK: begin
                CHK_RESET_N = 1'b1;
                state_nx    = REPORT;
            end
            REPORT: begin
                // a verdict overlapping reset is suppressed rather than half-emitted
                RES_VALID = !RESET;
                RES_PASS  = verdict && !RESET;
                if (!verdict && (fail_inc == FCW'(MAX_FAILS))) begin
                    state_nx = LOCKOUT;
                end else begin
                    state_nx = LOAD;
                end
            end
            LOCKOUT: begin
                LOCKED = 1'b1;
                if (lock_done) begin
                    state_nx = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow   <= 1'b0;
            verdict    <= 1'b0;
            fail_count <= '0;
            lock_cnt   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    rd_ptr <= '0;
                    if (buf_we) begin
                        wr_ptr <= wr_ptr + PW'(1);
                    end else if (xfer) begin
                        overflow <= 1'b1;
                    end
                end
                STREAM: begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                CHECK: begin
                    verdict <= CHK_GOOD && !overflow;
                end
                REPORT: begin
                    fail_count <= verdict ? '0 : fail_inc;
                    wr_ptr     <= '0;
                    overflow   <= 1'b0;
                    if (state_nx == LOCKOUT) begin
                        lock_cnt <= LCW'(LOCK_CYCLES - 1);
                    end
                end
                LOCKOUT: begin
                    if (lock_done) begin
                        fail_count <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - LCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // attempt storage is deliberately never cleared; only wr_ptr restarts
    always_ff @(posedge CLK) begin
        if (buf_we) begin
            buffer[wr_ptr[AW-1:0]] <= IN_BYTE;
        end
    end

endmodule

// File: tb/tb_gate_sequencer.sv
// Testbench for gate_sequencer: reference checker, monitor and scoreboarded attempts.
module tb_gate_sequencer;
    localparam int MAX_LEN     = 32;
    localparam int MAX_FAILS   = 3;
    localparam int LOCK_CYCLES = 1024;

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b1;
    logic [7:0] IN_BYTE  = 8'h00;
    logic       IN_VALID = 1'b0;
    logic       IN_LAST  = 1'b0;
    logic       IN_READY;
    logic [7:0] CHK_BYTE;
    logic       CHK_RESET_N;
    logic       CHK_GOOD;
    logic       RES_VALID;
    logic       RES_PASS;
    logic       LOCKED;
    logic [1:0] FAIL_COUNT;

    gate_sequencer #(
        .MAX_LEN    (MAX_LEN),
        .MAX_FAILS  (MAX_FAILS),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .IN_BYTE    (IN_BYTE),
        .IN_VALID   (IN_VALID),
        .IN_LAST    (IN_LAST),
        .IN_READY   (IN_READY),
        .CHK_BYTE   (CHK_BYTE),
        .CHK_RESET_N(CHK_RESET_N),
        .CHK_GOOD   (CHK_GOOD),
        .RES_VALID  (RES_VALID),
        .RES_PASS   (RES_PASS),
        .LOCKED     (LOCKED),
        .FAIL_COUNT (FAIL_COUNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic pass;
        int   nchk;
        int   lat;
    } obs_t;

    typedef struct {
        logic pass;
        int   nchk;
        int   lat;
        int   fc;
    } exp_t;

    obs_t       obs_q[$];
    exp_t       exp_q[$];
    logic [7:0] obs_bytes[$];
    logic [7:0] exp_bytes[$];
    logic [7:0] tx_q[$];
    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int last_cyc  = 0;
    int nchk      = 0;
    int lock_seen = 0;
    int model_fc  = 0;

    // Reference checker: match flag rises once the first three bytes were 41 42 43
    logic [1:0] chk_cnt = 2'd0;
    logic       chk_ok  = 1'b0;
    logic       chk_good_r = 1'b0;
    assign CHK_GOOD = chk_good_r;

    always @(posedge CLK) begin
        if (!CHK_RESET_N) begin
            chk_cnt    <= 2'd0;
            chk_ok     <= 1'b0;
            chk_good_r <= 1'b0;
        end else begin
            case (chk_cnt)
                2'd0: chk_ok <= (CHK_BYTE == 8'h41);
                2'd1: chk_ok <= chk_ok && (CHK_BYTE == 8'h42);
                2'd2: chk_good_r <= chk_ok && (CHK_BYTE == 8'h43);
                default: ;
            endcase
            if (chk_cnt != 2'd3) chk_cnt <= chk_cnt + 2'd1;
        end
    end

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RESET) begin
            nchk = 0;
            obs_bytes.delete();
        end else begin
            if (IN_VALID && IN_READY && IN_LAST) last_cyc = cyc;
            if (CHK_RESET_N) begin
                obs_bytes.push_back(CHK_BYTE);
                nchk++;
            end
            if (LOCKED) lock_seen++;
            if (RES_VALID) begin
                obs_q.push_back('{RES_PASS, nchk, cyc - last_cyc});
                nchk = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_attempt(output int acc);
        exp_t e;
        int   n;
        int   waited;
        logic ok;
        logic pre;
        n   = tx_q.size();
        pre = (n >= 3) && (tx_q[0] == 8'h41) && (tx_q[1] == 8'h42) && (tx_q[2] == 8'h43);
        e.pass = pre && (n <= MAX_LEN);
        e.nchk = ((n > MAX_LEN) ? MAX_LEN : n) + 1;
        e.lat  = e.nchk + 1;
        model_fc = e.pass ? 0 : ((model_fc == MAX_FAILS) ? MAX_FAILS : model_fc + 1);
        e.fc   = model_fc;
        exp_q.push_back(e);
        for (int i = 0; i < e.nchk - 1; i++) exp_bytes.push_back(tx_q[i]);
        exp_bytes.push_back(8'h00);
        acc = 0;
        for (int i = 0; i < n; i++) begin
            IN_VALID = 1'b1;
            IN_BYTE  = tx_q[i];
            IN_LAST  = (i == n - 1);
            waited = 0;
            ok     = 1'b0;
            while (!ok && waited < 64) begin
                @(negedge CLK);
                if (IN_READY) ok = 1'b1;
                else waited++;
            end
            @(posedge CLK);
            #1;
            if (!ok) break;
            acc++;
        end
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic wait_verdict(output logic got, output obs_t o, output exp_t e, output int bad);
        int         w;
        int         nobs;
        logic [7:0] eb;
        logic [7:0] ob;
        w   = 0;
        got = 1'b0;
        o   = '{1'b0, 0, 0};
        e   = '{1'b0, 0, 0, 0};
        while (obs_q.size() == 0 && w < 200) begin
            @(posedge CLK);
            #2;
            w++;
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (obs_q.size() > 0) begin
            got = 1'b1;
            o   = obs_q.pop_front();
        end
        nobs = got ? o.nchk : 0;
        bad  = 0;
        for (int i = 0; i < e.nchk || i < nobs; i++) begin
            eb = 8'h00;
            ob = 8'h00;
            if (i < e.nchk && exp_bytes.size() > 0) eb = exp_bytes.pop_front();
            if (i < nobs && obs_bytes.size() > 0) ob = obs_bytes.pop_front();
            if (i >= e.nchk || i >= nobs || ob !== eb) bad++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL rst_ready_during: got %0b want 0", IN_READY); end
        RESET = 1'b0;
        #1;
        checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL rst_ready_after: got %0b want 1", IN_READY); end
        checks++; if (CHK_RESET_N !== 1'b0) begin failures++; $display("FAIL rst_chk_reset_n: got %0b want 0", CHK_RESET_N); end
        checks++; if (CHK_BYTE !== 8'h00) begin failures++; $display("FAIL rst_chk_byte: got %h want 00", CHK_BYTE); end
        checks++; if (RES_VALID !== 1'b0 || RES_PASS !== 1'b0) begin failures++; $display("FAIL rst_res: got %0b/%0b want 0/0", RES_VALID, RES_PASS); end
        checks++; if (LOCKED !== 1'b0) begin failures++; $display("FAIL rst_locked: got %0b want 0", LOCKED); end
        checks++; if (FAIL_COUNT !== 2'd0) begin failures++; $display("FAIL rst_fail_count: got %0d want 0", FAIL_COUNT); end
    endtask

    task automatic test_pass();
        int acc; logic got; obs_t o; exp_t e; int bad;
        tx_q = '{8'h41, 8'h42, 8'h43};
        send_attempt(acc);
        wait_verdict(got, o, e, bad);
        checks++; if (acc !== 3) begin failures++; $display("FAIL pass_accepted: got %0d want 3", acc); end
        checks++; if (!got || o.pass !== 1'b1) begin failures++; $display("FAIL pass_verdict: got %0b (seen %0b) want 1", o.pass, got); end
        checks++; if (o.lat !== 5) begin failures++; $display("FAIL pass_latency: got %0d want 5", o.lat); end
        checks++; if (o.nchk !== 4 || bad !== 0) begin failures++; $display("FAIL pass_stream: got %0d cycles %0d bad want 4 cycles 0 bad", o.nchk, bad); end
        checks++; if (FAIL_COUNT !== 2'd0) begin failures++; $display("FAIL pass_fail_count: got %0d want 0", FAIL_COUNT); end
    endtask

    task automatic test_fail_recover();
        int acc; logic got; obs_t o; exp_t e; int bad; int lock0; int want_fc;
        lock0 = lock_seen;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) tx_q = '{8'h41, 8'h58};
            else       tx_q = '{8'h41, 8'h42, 8'h43};
            want_fc = (k == 0) ? 1 : (k == 1) ? 2 : 0;
            send_attempt(acc);
            wait_verdict(got, o, e, bad);
            checks++; if (!got || o.pass !== e.pass) begin failures++; $display("FAIL recover_verdict%0d: got %0b want %0b", k, o.pass, e.pass); end
            checks++; if (FAIL_COUNT !== 2'(want_fc)) begin failures++; $display("FAIL recover_fail_count%0d: got %0d want %0d", k, FAIL_COUNT, want_fc); end
        end
        checks++; if (lock_seen !== lock0) begin failures++; $display("FAIL recover_no_lock: got %0d locked cycles want 0", lock_seen - lock0); end
    endtask

    task automatic test_overflow();
        int acc; logic got; obs_t o; exp_t e; int bad;
        tx_q = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 30; i++) tx_q.push_back(8'(8'h50 + i));
        send_attempt(acc);
        checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL ovf_ready_in_stream: got %0b want 0", IN_READY); end
        wait_verdict(got, o, e, bad);
        checks++; if (acc !== 33) begin failures++; $display("FAIL ovf_accepted: got %0d want 33", acc); end
        checks++; if (!got || o.pass !== 1'b0) begin failures++; $display("FAIL ovf_verdict: got %0b (seen %0b) want 0", o.pass, got); end
        checks++; if (o.nchk !== 33 || bad !== 0) begin failures++; $display("FAIL ovf_stream: got %0d cycles %0d bad want 33 cycles 0 bad", o.nchk, bad); end
        checks++; if (o.lat !== 34) begin failures++; $display("FAIL ovf_latency: got %0d want 34", o.lat); end
        checks++; if (FAIL_COUNT !== 2'd1) begin failures++; $display("FAIL ovf_fail_count: got %0d want 1", FAIL_COUNT); end
    endtask

    task automatic test_single();
        int acc; logic got; obs_t o; exp_t e; int bad;
        tx_q = '{8'h41};
        send_attempt(acc);
        wait_verdict(got, o, e, bad);
        checks++; if (acc !== 1) begin failures++; $display("FAIL single_accepted: got %0d want 1", acc); end
        checks++; if (!got || o.pass !== 1'b0) begin failures++; $display("FAIL single_verdict: got %0b (seen %0b) want 0", o.pass, got); end
        checks++; if (o.lat !== 3) begin failures++; $display("FAIL single_latency: got %0d want 3", o.lat); end
        checks++; if (o.nchk !== 2 || bad !== 0) begin failures++; $display("FAIL single_stream: got %0d cycles %0d bad want 2 cycles 0 bad", o.nchk, bad); end
        checks++; if (FAIL_COUNT !== 2'd2) begin failures++; $display("FAIL single_fail_count: got %0d want 2", FAIL_COUNT); end
    endtask

    task automatic test_back_to_back();
        int acc1; int acc2; logic got; obs_t o; exp_t e; int bad;
        tx_q = '{8'h41, 8'h42, 8'h43};
        send_attempt(acc1);
        tx_q = '{8'h41, 8'h58};
        send_attempt(acc2);
        wait_verdict(got, o, e, bad);
        checks++; if (!got || o.pass !== 1'b1 || o.lat !== 5) begin failures++; $display("FAIL b2b_first: got pass %0b lat %0d want pass 1 lat 5", o.pass, o.lat); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_first_stream: got %0d bad bytes want 0", bad); end
        wait_verdict(got, o, e, bad);
        checks++; if (acc1 !== 3 || acc2 !== 2) begin failures++; $display("FAIL b2b_accepted: got %0d/%0d want 3/2", acc1, acc2); end
        checks++; if (!got || o.pass !== 1'b0) begin failures++; $display("FAIL b2b_second: got %0b (seen %0b) want 0", o.pass, got); end
        checks++; if (o.nchk !== 3 || bad !== 0) begin failures++; $display("FAIL b2b_second_stream: got %0d cycles %0d bad want 3 cycles 0 bad", o.nchk, bad); end
        checks++; if (FAIL_COUNT !== 2'd1) begin failures++; $display("FAIL b2b_fail_count: got %0d want 1", FAIL_COUNT); end
    endtask

    task automatic test_stream_reset();
        int acc; exp_t e;
        tx_q = '{8'h41, 8'h42, 8'h43};
        send_attempt(acc);
        @(posedge CLK);
        #1;
        checks++; if (CHK_BYTE !== 8'h42 || CHK_RESET_N !== 1'b1) begin failures++; $display("FAIL srst_byte1: got %h/%0b want 42/1", CHK_BYTE, CHK_RESET_N); end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        checks++; if (CHK_RESET_N !== 1'b0) begin failures++; $display("FAIL srst_chk_reset_n: got %0b want 0", CHK_RESET_N); end
        checks++; if (IN_READY !== 1'b0 || RES_VALID !== 1'b0) begin failures++; $display("FAIL srst_outputs: got ready %0b valid %0b want 0 0", IN_READY, RES_VALID); end
        RESET = 1'b0;
        #1;
        checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL srst_ready_after: got %0b want 1", IN_READY); end
        checks++; if (FAIL_COUNT !== 2'd0) begin failures++; $display("FAIL srst_fail_count: got %0d want 0", FAIL_COUNT); end
        repeat (10) @(posedge CLK);
        #2;
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL srst_no_verdict: got %0d verdicts want 0", obs_q.size()); end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        exp_bytes.delete();
        obs_q.delete();
        model_fc = 0;
    endtask

    task automatic test_lockout();
        int acc; logic got; obs_t o; exp_t e; int bad; int n; int bad_rdy;
        for (int k = 0; k < 3; k++) begin
            tx_q = '{8'h41, 8'h58};
            send_attempt(acc);
            wait_verdict(got, o, e, bad);
            checks++; if (!got || o.pass !== 1'b0) begin failures++; $display("FAIL lock_verdict%0d: got %0b (seen %0b) want 0", k, o.pass, got); end
            checks++; if (FAIL_COUNT !== 2'(k + 1)) begin failures++; $display("FAIL lock_fail_count%0d: got %0d want %0d", k, FAIL_COUNT, k + 1); end
        end
        checks++; if (LOCKED !== 1'b1) begin failures++; $display("FAIL lock_entry: got %0b want 1", LOCKED); end
        n = 0;
        bad_rdy = 0;
        while (LOCKED === 1'b1 && n < 2000) begin
            if (IN_READY !== 1'b0 || CHK_RESET_N !== 1'b0) bad_rdy++;
            n++;
            @(posedge CLK);
            #2;
        end
        checks++; if (n !== LOCK_CYCLES) begin failures++; $display("FAIL lock_duration: got %0d want %0d", n, LOCK_CYCLES); end
        checks++; if (bad_rdy !== 0) begin failures++; $display("FAIL lock_ready_low: got %0d bad cycles want 0", bad_rdy); end
        checks++; if (FAIL_COUNT !== 2'd0 || IN_READY !== 1'b1) begin failures++; $display("FAIL lock_exit: got count %0d ready %0b want 0 1", FAIL_COUNT, IN_READY); end
        model_fc = 0;
        tx_q = '{8'h41, 8'h42, 8'h43};
        send_attempt(acc);
        wait_verdict(got, o, e, bad);
        checks++; if (!got || o.pass !== 1'b1 || bad !== 0) begin failures++; $display("FAIL lock_after_pass: got %0b (seen %0b, %0d bad) want 1", o.pass, got, bad); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_recover();
        test_overflow();
        test_single();
        test_back_to_back();
        test_stream_reset();
        test_lockout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_sequencer.md
GATE_SEQUENCER -- requirements
Module: gate_sequencer

Interface
REQ-001 Parameter MAX_LEN, default 32, SHALL set the maximum attempt length in bytes and the buffer depth.
REQ-002 Parameter MAX_FAILS, default 3, SHALL set the consecutive failures that trigger lockout.
REQ-003 Parameter LOCK_CYCLES, default 1024, SHALL set the lockout duration in clock cycles.
REQ-004 CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 RESET  input  1  reset, synchronous, active-high.
REQ-006 IN_BYTE  input  8  attempt byte from requester.
REQ-007 IN_VALID  input  1  IN_BYTE valid.
REQ-008 IN_LAST  input  1  qualifies IN_BYTE as final byte of attempt.
REQ-009 IN_READY  output  1  sequencer accepts byte this cycle.
REQ-010 CHK_BYTE  output  8  byte driven to password checker.
REQ-011 CHK_RESET_N  output  1  checker sync reset, active-low.
REQ-012 CHK_GOOD  input  1  checker registered match flag.
REQ-013 RES_VALID  output  1  one-cycle verdict strobe.
REQ-014 RES_PASS  output  1  verdict, valid when RES_VALID=1.
REQ-015 LOCKED  output  1  lockout active.
REQ-016 FAIL_COUNT  output  $clog2(MAX_FAILS+1)  consecutive failure count.

Function
REQ-017 FSM states SHALL be LOAD, STREAM, CHECK, REPORT, LOCKOUT; handshake transfer = IN_VALID & IN_READY.
REQ-018 LOAD: IN_READY=1, CHK_RESET_N=0, CHK_BYTE=0; each transfer writes buffer[wr_ptr], wr_ptr+1.
REQ-019 Transfers beyond MAX_LEN bytes SHALL be accepted and discarded and SHALL set an overflow flag for the attempt.
REQ-020 Transfer with IN_LAST=1 SHALL move LOAD->STREAM next cycle; length = bytes stored (1..MAX_LEN).
REQ-021 STREAM: IN_READY=0, CHK_RESET_N=1, CHK_BYTE=buffer[k] in the k-th STREAM cycle, k=0..len-1, back-to-back, no gaps.
REQ-022 After the cycle presenting buffer[len-1], FSM SHALL enter CHECK for exactly one cycle with CHK_RESET_N=1, CHK_BYTE=0, and sample CHK_GOOD.
REQ-023 Verdict pass = sampled CHK_GOOD & ~overflow.
REQ-024 REPORT: RES_VALID=1, RES_PASS=verdict for exactly one cycle; CHK_RESET_N=0; IN_READY=0.
REQ-025 On pass FAIL_COUNT SHALL clear to 0; on fail it SHALL increment, saturating at MAX_FAILS.
REQ-026 REPORT->LOCKOUT if FAIL_COUNT reaches MAX_FAILS in that update, else REPORT->LOAD with wr_ptr and overflow cleared.
REQ-027 LOCKOUT: LOCKED=1, IN_READY=0, CHK_RESET_N=0; down-counter loaded with LOCK_CYCLES-1 on entry; exit to LOAD the cycle after counter reads 0, FAIL_COUNT cleared on exit.
REQ-028 Latency: last-byte transfer at cycle T -> RES_VALID at cycle T+len+2.
REQ-029 IN_VALID held while IN_READY=0 SHALL NOT be consumed; IN_BYTE/IN_LAST ignored outside LOAD.
REQ-030 Buffer contents SHALL NOT be cleared between attempts; only wr_ptr resets.

Reset
REQ-031 RESET=1 at any state, including mid-STREAM or mid-LOCKOUT, SHALL next cycle give: state LOAD, wr_ptr=0, overflow=0, FAIL_COUNT=0, lock counter=0, IN_READY=0 during reset then 1, CHK_RESET_N=0, CHK_BYTE=0, RES_VALID=0, RES_PASS=0, LOCKED=0.
REQ-032 No partial verdict SHALL be emitted for an attempt interrupted by RESET.

Verification (bench checker model: CHK_GOOD=1 the cycle after sequence 0x41,0x42,0x43 completes)
REQ-033 Send 0x41,0x42,0x43(LAST) -> CHK_BYTE 0x41,0x42,0x43 consecutive cycles, RES_VALID at T+5, RES_PASS=1, FAIL_COUNT=0.
REQ-034 Send 0x41,0x58(LAST) three times -> RES_PASS=0 each, FAIL_COUNT 1,2,3, LOCKED=1 for 1024 cycles, IN_READY=0 throughout, then FAIL_COUNT=0, IN_READY=1.
REQ-035 Send 33 bytes with correct prefix 0x41,0x42,0x43 (MAX_LEN=32) -> all 33 accepted, 32 streamed, RES_PASS=0, FAIL_COUNT=1.
REQ-036 Two fails then correct attempt -> FAIL_COUNT 1,2,0, LOCKED never asserted.
REQ-037 Assert RESET during STREAM byte 1 -> next cycle CHK_RESET_N=0, no RES_VALID, IN_READY=1 after release, FAIL_COUNT=0.
REQ-038 Single-byte attempt 0x41(LAST) -> one STREAM cycle, RES_VALID at T+3, RES_PASS=0.
